// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared defaults and stage-count helper for the pipelined adder
package adder_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_CHUNK = 4;

    // Guards the division so a bad CHUNK reaches the top-level elaboration check cleanly
    function automatic int adder_stages(input int width, input int chunk);
        return (chunk < 1) ? 1 : width / chunk;
    endfunction

endpackage

// File: rtl/chunk_adder.sv
// rtl/chunk_adder.sv - combinational CHUNK-bit ripple adder built from full_adder cells
module chunk_adder
    import adder_pkg::*;
#(
    parameter int CHUNK = DEFAULT_CHUNK
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             ci_i,
    output logic [CHUNK-1:0] s_o,
    output logic             co_o,
    output logic             c_msb_o
);

    logic [CHUNK:0] carry;

    assign carry[0] = ci_i;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        full_adder u_fa (
            .a_i  (a_i[i]),
            .b_i  (b_i[i]),
            .ci_i (carry[i]),
            .s_o  (s_o[i]),
            .co_o (carry[i+1])
        );
    end

    assign co_o    = carry[CHUNK];
    // Carry into the top bit of this chunk; the last stage uses it for signed overflow
    assign c_msb_o = carry[CHUNK-1];

endmodule

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full adder cell
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic ci_i,
    output logic s_o,
    output logic co_o
);

    assign s_o  = a_i ^ b_i ^ ci_i;
    assign co_o = (a_i & b_i) | (ci_i & (a_i ^ b_i));

endmodule

// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - WIDTH-bit adder pipelined as CHUNK-bit ripple slices with valid/ready
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CHUNK = DEFAULT_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf
);

    localparam int STAGES = adder_stages(WIDTH, CHUNK);

    if (CHUNK < 1) begin : g_chunk_check
        $error("pipelined_adder: CHUNK must be at least 1");
    end else if (WIDTH % CHUNK != 0) begin : g_width_check
        $error("pipelined_adder: WIDTH must be a multiple of CHUNK");
    end

    logic             vld_q   [STAGES];
    logic             vld_d   [STAGES];
    logic [WIDTH-1:0] a_q     [STAGES];
    logic [WIDTH-1:0] a_d     [STAGES];
    logic [WIDTH-1:0] b_q     [STAGES];
    logic [WIDTH-1:0] b_d     [STAGES];
    logic [WIDTH-1:0] sum_q   [STAGES];
    logic [WIDTH-1:0] sum_d   [STAGES];
    logic             c_q     [STAGES];
    logic             c_d     [STAGES];
    logic             msb_c_q;
    logic             msb_c_d;

    logic [WIDTH-1:0] src_a   [STAGES];
    logic [WIDTH-1:0] src_b   [STAGES];
    logic [WIDTH-1:0] src_sum [STAGES];
    logic             src_c   [STAGES];

    logic [CHUNK-1:0] ch_s    [STAGES];
    logic             ch_co   [STAGES];
    logic             ch_msb  [STAGES];

    logic stall;
    logic advance;

    assign stall    = vld_q[STAGES-1] && !out_ready;
    assign advance  = !stall;
    assign in_ready = !stall;

    // Stage k reads the skewed operands and partial sum held by stage k-1 (the ports for k=0)
    always_comb begin
        src_a[0]   = a;
        src_b[0]   = b;
        src_c[0]   = ci;
        src_sum[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            src_a[k]   = a_q[k-1];
            src_b[k]   = b_q[k-1];
            src_c[k]   = c_q[k-1];
            src_sum[k] = sum_q[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        chunk_adder #(
            .CHUNK (CHUNK)
        ) u_chunk (
            .a_i     (src_a[k][k*CHUNK +: CHUNK]),
            .b_i     (src_b[k][k*CHUNK +: CHUNK]),
            .ci_i    (src_c[k]),
            .s_o     (ch_s[k]),
            .co_o    (ch_co[k]),
            .c_msb_o (ch_msb[k])
        );
    end

    always_comb begin
        vld_d[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            vld_d[k] = vld_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            a_d[k]                     = src_a[k];
            b_d[k]                     = src_b[k];
            sum_d[k]                   = src_sum[k];
            sum_d[k][k*CHUNK +: CHUNK] = ch_s[k];
            c_d[k]                     = ch_co[k];
        end
        msb_c_d = ch_msb[STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_q[k] <= 1'b0;
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                sum_q[k] <= '0;
                c_q[k]   <= 1'b0;
            end
            msb_c_q <= 1'b0;
        end else if (advance) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_q[k] <= vld_d[k];
                a_q[k]   <= a_d[k];
                b_q[k]   <= b_d[k];
                sum_q[k] <= sum_d[k];
                c_q[k]   <= c_d[k];
            end
            msb_c_q <= msb_c_d;
        end
    end

    assign out_valid = vld_q[STAGES-1];
    assign s         = sum_q[STAGES-1];
    assign co        = c_q[STAGES-1];
    assign ovf       = msb_c_q ^ c_q[STAGES-1];

endmodule

// File: tb/tb_pipelined_adder.sv
// tb/tb_pipelined_adder.sv - randomized and directed self-checking bench for pipelined_adder
module tb_pipelined_adder;

    localparam int W = 8;
    localparam int C = 4;
    localparam int S = W / C;

    typedef struct packed {
        logic         v;
        logic [W-1:0] s;
        logic         co;
        logic         ovf;
    } slot_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] s;
    logic         co;
    logic         ovf;

    slot_t mdl [S];
    int    checks = 0;
    int    errors = 0;

    pipelined_adder #(
        .WIDTH (W),
        .CHUNK (C)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ci        (ci),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .co        (co),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic, unsigned for carry, signed range for overflow
    function automatic slot_t ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        slot_t r;
        int unsigned u;
        int sx;
        int sy;
        int sg;
        u  = int'(x) + int'(y) + int'(c);
        sx = $signed(x);
        sy = $signed(y);
        sg = sx + sy + int'(c);
        r.v   = 1'b1;
        r.s   = u[W-1:0];
        r.co  = (u > 255);
        r.ovf = (sg > 127) || (sg < -128);
        return r;
    endfunction

    // One clock: drive inputs, check the pre-edge view against the delay-line model, clock
    task automatic cycle(input logic v, input logic [W-1:0] xa, input logic [W-1:0] xb,
                         input logic xc, input logic ordy, input logic r);
        logic exp_ready;
        rst       = r;
        in_valid  = v;
        a         = xa;
        b         = xb;
        ci        = xc;
        out_ready = ordy;
        #1;
        exp_ready = !(mdl[S-1].v && !ordy);
        check("in_ready", in_ready, exp_ready);
        check("out_valid", out_valid, mdl[S-1].v);
        if (mdl[S-1].v) begin
            check("s", s, mdl[S-1].s);
            check("co", co, mdl[S-1].co);
            check("ovf", ovf, mdl[S-1].ovf);
        end
        if (r) begin
            for (int k = 0; k < S; k++) mdl[k] = '0;
        end else if (exp_ready) begin
            for (int k = S - 1; k > 0; k--) mdl[k] = mdl[k-1];
            mdl[0] = v ? ref_add(xa, xb, xc) : slot_t'('0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [W-1:0] xs,
                              input logic xco, input logic xovf);
        check({tag, "_valid"}, out_valid, v);
        check({tag, "_s"}, s, xs);
        check({tag, "_co"}, co, xco);
        check({tag, "_ovf"}, ovf, xovf);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        for (int k = 0; k < S; k++) mdl[k] = '0;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; ci = 1'b0; out_ready = 1'b1;
        cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
        cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
        expect_out("reset", 1'b0, 8'h00, 1'b0, 1'b0);
        check("reset_in_ready", in_ready, 1'b1);

        // Carry crosses the chunk boundary
        cycle(1'b1, 8'hFF, 8'h01, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        expect_out("ff_01", 1'b1, 8'h00, 1'b1, 1'b0);

        cycle(1'b1, 8'h7F, 8'h01, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 8'h80, 8'h80, 1'b0, 1'b1, 1'b0);
        expect_out("7f_01", 1'b1, 8'h80, 1'b0, 1'b1);
        cycle(1'b1, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
        expect_out("80_80", 1'b1, 8'h00, 1'b1, 1'b1);
        cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        expect_out("ci_only", 1'b1, 8'h01, 1'b0, 1'b0);
        idle(2);

        // Back-to-back stream
        cycle(1'b1, 8'h0F, 8'h01, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 8'h10, 8'h10, 1'b0, 1'b1, 1'b0);
        expect_out("stream0", 1'b1, 8'h10, 1'b0, 1'b0);
        cycle(1'b1, 8'hF0, 8'h20, 1'b0, 1'b1, 1'b0);
        expect_out("stream1", 1'b1, 8'h20, 1'b0, 1'b0);
        cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        expect_out("stream2", 1'b1, 8'h10, 1'b1, 1'b0);
        cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        check("stream_end_valid", out_valid, 1'b0);
        idle(1);

        // Stall with two results in flight; offered input must not be taken
        cycle(1'b1, 8'h11, 8'h22, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 8'h33, 8'h44, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 8'h55, 8'h66, 1'b0, 1'b0, 1'b0);
            expect_out("stall_hold", 1'b1, 8'h33, 1'b0, 1'b0);
            check("stall_in_ready", in_ready, 1'b0);
        end
        cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        expect_out("stall_rel", 1'b1, 8'h77, 1'b0, 1'b0);
        cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        check("stall_drain_valid", out_valid, 1'b0);

        // Reset with operations in flight
        cycle(1'b1, 8'hAA, 8'h11, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 8'hBB, 8'h22, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 8'hCC, 8'h33, 1'b0, 1'b1, 1'b1);
        expect_out("mid_reset", 1'b0, 8'h00, 1'b0, 1'b0);
        idle(3);

        // Randomized traffic with backpressure and occasional reset
        for (int i = 0; i < 3000; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), W'($urandom), W'($urandom), 1'($urandom),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 199) == 0));
        end
        idle(S + 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
